bo_share_arbiter: RTL
=====================

// Module: bo_share_arbiter
// PURPOSE
//  Time-multiplexes one shared BO datapath among N_REQ requesters. Its companion control FSM drives the BO internally.
//  Round-robin arbiter: latches the winner's operand onto dp_x, pulses the start input dp_w, waits for dp_done,
//  captures dp_result and returns it with a one-cycle ack to the winner.
//  Sits between requester blocks and the BC/BO pair at the top level.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  DATA_W   8     operand/result width
//  TO_CYC   64    WAIT-state timeout in cycles (used only with BO_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             reset, synchronous, active-high
//  req        in   N_REQ         level request per requester
//  x_in       in   N_REQ*DATA_W  packed operands; requester i at [i*DATA_W +: DATA_W]
//  gnt        out  N_REQ         one-hot grant, held for the whole operation
//  ack        out  N_REQ         one-hot, one-cycle completion pulse
//  result     out  DATA_W        result for the acked requester; valid while ack!=0, held after
//  dp_x       out  DATA_W        operand to the shared datapath, stable from START to ACK
//  dp_w       out  1             datapath start pulse, exactly one cycle
//  dp_done    in   1             datapath completion flag
//  dp_result  in   DATA_W        datapath result, sampled when dp_done=1 in WAIT
//  busy       out  1             1 in every state except IDLE
//  err        out  1             timeout pulse, coincident with ack; tied 0 without the macro
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, gnt=0, ack=0, result=0, dp_x=0, dp_w=0, busy=0, err=0. Mid-operation rst aborts.
//   No ack is issued. The datapath shares rst.
//  FSM, registered outputs, one transition per clk:
//   IDLE : req==0 -> stay. Otherwise sel = first set bit scanning ptr, ptr+1, ..., ptr-1 (mod N_REQ).
//          gnt<=onehot(sel), dp_x<=x_in[sel] -> START.
//   START: dp_w=1 for this cycle only -> WAIT. dp_done is ignored in this cycle.
//   WAIT : dp_w=0. If dp_done=1: result<=dp_result -> ACK. Else stay.
//   ACK  : ack=onehot(sel) for one cycle, gnt<=0, ptr<=(sel+1) mod N_REQ -> IDLE.
//  Latency: req edge -> dp_w high is 2 cycles. dp_done sampled -> ack is 1 cycle.
//   Minimum back-to-back period is 4 cycles plus datapath time.
//  req dropped while granted: ignored; the operation completes and ack is still pulsed.
//  req still high in the cycle after ack: re-arbitrated at lowest priority. Fairness is strict round-robin.
//  Multiple simultaneous reqs: only sel proceeds; the others wait, and their x_in is not sampled until granted.
//  x_in[sel] changes after grant: no effect, because dp_x is latched.
//  ptr wraps N_REQ-1 -> 0. N_REQ not a power of two: the modulo is explicit, not a bit truncation.
//  Encoding is binary 2-bit: IDLE=0, START=1, WAIT=2, ACK=3. Unreachable codes are impossible with 4 states.
// CONFIGURATION
//  BO_ARB_TIMEOUT_EN defined:
//   - A counter of width $clog2(TO_CYC+1) clears on START and increments in WAIT.
//   - When it reaches TO_CYC with dp_done still 0: result<=0 -> ACK, and err=1 in the ACK cycle.
//   - dp_done arriving in the same cycle as the timeout takes priority: normal completion, err=0.
//  BO_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; err is constant 0.
// STRUCTURE
//  Shared include bo_arb_pkg.vh holds the state-code localparams (S_IDLE..S_ACK) and the onehot/modulo helper functions.
//  Sub-module rr_priority_pick: combinational rotating priority encoder.
//   (req, ptr) -> (any, sel index); parameterised on N_REQ; reusable by other arbiters.
//  Top holds the FSM, ptr, the operand/result registers and the optional timeout counter.
// TESTING  (N_REQ=4, DATA_W=8, TO_CYC=64; datapath model asserts dp_done K cycles after dp_w)
//  1 Single request: req=4'b0010, x_in[1]=8'h5A, K=6.
//    -> dp_x=8'h5A and dp_w=1 two cycles after req; ack=4'b0010 with result=model(8'h5A); ptr=2.
//  2 All requesting: req=4'b1111 held, ptr=0.
//    -> grant order 0,1,2,3,0; each ack one cycle; never two gnt bits set.
//  3 Drop request: req[2] dropped during WAIT.
//    -> ack[2] still pulses. req[2] held after its ack while req[3]=1 -> requester 3 is served next.
//  4 Reset: rst=1 in WAIT (sync).
//    -> next edge: all outputs 0, state IDLE, no ack; new request after release is served from ptr=0.
//  5 Timeout with macro, dp_done never asserted.
//    -> ack plus err=1 and result=0 exactly 64 cycles after the first WAIT cycle.
//    dp_done at cycle 64 -> err=0. Without the macro the bench waits 200 cycles: still WAIT, err=0.
//  6 Operand latching: x_in[0] changed 8'h11->8'h22 one cycle after grant.
//    -> dp_x stays 8'h11 through ACK.

Source files
------------

// File: rtl/bo_share_arbiter_pkg.sv
// bo_share_arbiter_pkg: FSM state codes and index helpers shared by the arbiter files
package bo_share_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam int MAX_REQ = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input int i);
        return MAX_REQ'(1) << i;
    endfunction

    // modulo add for a + b < 2n, explicit so non-power-of-two counts wrap correctly
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/bo_share_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational rotating priority encoder, first request at or after ptr wins
module rr_priority_pick
    import bo_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    sel
);

    logic [PW-1:0] idx;

    // scan from the farthest offset back toward ptr so the nearest requester is written last
    always_comb begin
        any = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'(wrap_add(int'(ptr), k, N_REQ));
            if (req[idx]) begin
                any = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/bo_share_arbiter.sv
// bo_share_arbiter: round-robin sharing of one start/done datapath; optional WAIT timeout via BO_ARB_TIMEOUT_EN
module bo_share_arbiter
    import bo_share_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int TO_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] x_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       result,
    output logic [DATA_W-1:0]       dp_x,
    output logic                    dp_w,
    input  logic                    dp_done,
    input  logic [DATA_W-1:0]       dp_result,
    output logic                    busy,
    output logic                    err
);

    localparam int PW = $clog2(N_REQ);

    state_t        state, state_n;
    logic [PW-1:0] ptr, sel, pick;
    logic          any, tmo;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req(req),
        .ptr(ptr),
        .any(any),
        .sel(pick)
    );

`ifdef BO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt;

    // WAIT cycle counter; the last allowed WAIT cycle is the one holding TO_CYC-1
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (state == S_START)
            cnt <= '0;
        else if (state == S_WAIT)
            cnt <= cnt + 1'b1;
    end

    assign tmo = (state == S_WAIT) && !dp_done && (cnt == CW'(TO_CYC - 1));
`else
    assign tmo = (TO_CYC < 0);
`endif

    assign busy = (state != S_IDLE);

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next-state: one step per clock, dp_done wins over a simultaneous timeout
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = any ? S_START : S_IDLE;
            S_START: state_n = S_WAIT;
            S_WAIT:  state_n = (dp_done || tmo) ? S_ACK : S_WAIT;
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // registered outputs: grant/operand latch on arbitration, result capture, single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            sel    <= '0;
            gnt    <= '0;
            ack    <= '0;
            result <= '0;
            dp_x   <= '0;
            dp_w   <= 1'b0;
            err    <= 1'b0;
        end else begin
            dp_w <= 1'b0;
            ack  <= '0;
            err  <= 1'b0;
            case (state)
                S_IDLE: if (any) begin
                    sel  <= pick;
                    gnt  <= N_REQ'(onehot(int'(pick)));
                    dp_x <= x_in[pick*DATA_W +: DATA_W];
                    dp_w <= 1'b1;
                end
                S_WAIT: if (dp_done) begin
                    result <= dp_result;
                    ack    <= gnt;
                end else if (tmo) begin
                    result <= '0;
                    ack    <= gnt;
                    err    <= 1'b1;
                end
                S_ACK: begin
                    gnt <= '0;
                    ptr <= PW'(wrap_add(int'(sel), 1, N_REQ));
                end
                default: ;
            endcase
        end
    end

endmodule
